// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and helpers for the byte-serialising memory controller.
//   state_e      : controller FSM states
//   LEN1/2/4     : load/store byte-count codes
//   len_bytes()  : byte count for a length code (unknown codes are treated as 4)
//   insert_byte(): replace one byte lane of a little-endian word
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MEM_CTRL_IDLE   = 3'd0,
    MEM_CTRL_IF_RD  = 3'd1,
    MEM_CTRL_MEM_RD = 3'd2,
    MEM_CTRL_MEM_WR = 3'd3,
    MEM_CTRL_DONE   = 3'd4
  } state_e;

  localparam int          WORD_W    = 32;
  localparam int          BYTE_W    = 8;
  localparam logic [2:0]  LEN1      = 3'd1;
  localparam logic [2:0]  LEN2      = 3'd2;
  localparam logic [2:0]  LEN4      = 3'd4;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  function automatic logic [2:0] len_bytes(input logic [2:0] len);
    logic [2:0] n;
    case (len)
      LEN1:    n = 3'd1;
      LEN2:    n = 3'd2;
      LEN4:    n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the IF requester, MEM requester and byte-wide RAM port of mem_ctrl.
//   IF side  : flush_i, if_req_i, if_addr_i -> if_done_o, if_inst_o
//   MEM side : mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i
//              -> mem_done_o, mem_rdata_o
//   RAM side : ram_addr_o, ram_wr_o, ram_dout_o <- ram_din_i
// modport slave  : the controller view
// modport master : the requester / RAM view
// ----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              flush_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [31:0]       if_inst_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [2:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport slave (
    input  flush_i, if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_done_o, if_inst_o, mem_done_o, mem_rdata_o,
    output ram_addr_o, ram_wr_o, ram_dout_o
  );

  modport master (
    output flush_i, if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_done_o, if_inst_o, mem_done_o, mem_rdata_o,
    input  ram_addr_o, ram_wr_o, ram_dout_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates one byte-wide RAM port between instruction fetch (IF) and
// load/store (MEM). Fetches are 4 bytes, loads/stores 1, 2 or 4 bytes, all
// serialised little-endian. A one-cycle done pulse returns the result.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   io_bus : mem_ctrl_if.slave (IF, MEM and RAM signals)
// All outputs are registered; requests are sampled only in IDLE, where MEM
// has priority over IF.
// ----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mem_ctrl_if.slave  io_bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_e            r_state, w_state;
  logic [2:0]        r_cnt, w_cnt;
  logic [2:0]        r_len, w_len;
  logic              r_is_if, w_is_if;
  logic [31:0]       r_buf, w_buf;
  logic [23:0]       r_wshift, w_wshift;
  logic              r_if_done, w_if_done;
  logic [31:0]       r_if_inst, w_if_inst;
  logic              r_mem_done, w_mem_done;
  logic [31:0]       r_mem_rdata, w_mem_rdata;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic              r_ram_wr, w_ram_wr;
  logic [7:0]        r_ram_dout, w_ram_dout;

  logic [1:0]        w_byte_idx;
  logic [31:0]       w_rd_word;

  // RAM data arriving in busy cycle k belongs to byte k-1.
  assign w_byte_idx = r_cnt[1:0] - 2'd1;

  // Next-state and next-output logic of the controller FSM.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_is_if     = r_is_if;
    w_buf       = r_buf;
    w_wshift    = r_wshift;
    w_if_done   = 1'b0;
    w_if_inst   = r_if_inst;
    w_mem_done  = 1'b0;
    w_mem_rdata = r_mem_rdata;
    w_ram_addr  = r_ram_addr;
    w_ram_wr    = 1'b0;
    w_ram_dout  = r_ram_dout;

    // Shared shift-in: merge this cycle's RAM byte into the partial word.
    if (r_cnt != 3'd0) begin
      w_rd_word = insert_byte(r_buf, w_byte_idx, io_bus.ram_din_i);
    end else begin
      w_rd_word = r_buf;
    end

    case (r_state)
      MEM_CTRL_IDLE: begin
        if (io_bus.mem_req_i) begin
          w_is_if    = 1'b0;
          w_len      = len_bytes(io_bus.mem_len_i);
          w_cnt      = 3'd0;
          w_buf      = ZERO_WORD;
          w_ram_addr = io_bus.mem_addr_i;
          if (io_bus.mem_we_i) begin
            // First store byte goes out in the very next cycle.
            w_state    = MEM_CTRL_MEM_WR;
            w_ram_wr   = 1'b1;
            w_ram_dout = io_bus.mem_wdata_i[7:0];
            w_wshift   = io_bus.mem_wdata_i[31:8];
          end else begin
            w_state = MEM_CTRL_MEM_RD;
          end
        end else if (io_bus.if_req_i && !io_bus.flush_i) begin
          w_state    = MEM_CTRL_IF_RD;
          w_is_if    = 1'b1;
          w_len      = LEN4;
          w_cnt      = 3'd0;
          w_buf      = ZERO_WORD;
          w_ram_addr = io_bus.if_addr_i;
        end else begin
          w_state = MEM_CTRL_IDLE;
        end
      end

      MEM_CTRL_IF_RD, MEM_CTRL_MEM_RD: begin
        if ((r_state == MEM_CTRL_IF_RD) && io_bus.flush_i) begin
          // Abandon the fetch; if_inst_o keeps its previous value.
          w_state = MEM_CTRL_IDLE;
        end else begin
          w_cnt = r_cnt + 3'd1;
          w_buf = w_rd_word;
          if ((r_cnt + 3'd1) < r_len) begin
            w_ram_addr = r_ram_addr + ADDR_ONE;
          end else begin
            w_ram_addr = r_ram_addr;
          end
          if (r_cnt == r_len) begin
            w_state = MEM_CTRL_DONE;
            if (r_is_if) begin
              w_if_done = 1'b1;
              w_if_inst = w_rd_word;
            end else begin
              w_mem_done  = 1'b1;
              w_mem_rdata = w_rd_word;
            end
          end else begin
            w_state = r_state;
          end
        end
      end

      MEM_CTRL_MEM_WR: begin
        if ((r_cnt + 3'd1) < r_len) begin
          w_cnt      = r_cnt + 3'd1;
          w_ram_addr = r_ram_addr + ADDR_ONE;
          w_ram_wr   = 1'b1;
          w_ram_dout = r_wshift[7:0];
          w_wshift   = {8'h00, r_wshift[23:8]};
        end else begin
          w_state    = MEM_CTRL_DONE;
          w_mem_done = 1'b1;
        end
      end

      MEM_CTRL_DONE: begin
        w_state = MEM_CTRL_IDLE;
      end

      default: begin
        w_state = MEM_CTRL_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= MEM_CTRL_IDLE;
      r_cnt       <= 3'd0;
      r_len       <= 3'd0;
      r_is_if     <= 1'b0;
      r_buf       <= ZERO_WORD;
      r_wshift    <= 24'h00_0000;
      r_if_done   <= 1'b0;
      r_if_inst   <= ZERO_WORD;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= ZERO_WORD;
      r_ram_addr  <= ADDR_ZERO;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_len       <= w_len;
      r_is_if     <= w_is_if;
      r_buf       <= w_buf;
      r_wshift    <= w_wshift;
      r_if_done   <= w_if_done;
      r_if_inst   <= w_if_inst;
      r_mem_done  <= w_mem_done;
      r_mem_rdata <= w_mem_rdata;
      r_ram_addr  <= w_ram_addr;
      r_ram_wr    <= w_ram_wr;
      r_ram_dout  <= w_ram_dout;
    end
  end

  assign io_bus.if_done_o   = r_if_done;
  assign io_bus.if_inst_o   = r_if_inst;
  assign io_bus.mem_done_o  = r_mem_done;
  assign io_bus.mem_rdata_o = r_mem_rdata;
  assign io_bus.ram_addr_o  = r_ram_addr;
  assign io_bus.ram_wr_o    = r_ram_wr;
  assign io_bus.ram_dout_o  = r_ram_dout;

endmodule

// File: tb/tb_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed stimulus for mem_ctrl with a scoreboard: expected done pulses and
// RAM writes are queued when a request is issued; a negedge monitor pops and
// compares whenever the DUT pulses a done or drives a RAM write.
// Cycle numbers: a request driven just after a rising edge is "seen" in that
// cycle t; the monitor samples with the same cycle index at the falling edge.
// ----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  // Cycle counter used to time-stamp expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 128 bytes, address folded to {a[10:8], a[3:0]}.
  logic [7:0] ram [128];

  function automatic logic [6:0] ridx(input logic [31:0] a);
    return {a[10:8], a[3:0]};
  endfunction

  function automatic logic [7:0] init_byte(input logic [6:0] i);
    case (i)
      7'd16: return 8'h13;  7'd17: return 8'h05;  // 0x100..0x103
      7'd18: return 8'h10;  7'd19: return 8'h00;
      7'd8:  return 8'h93;  7'd9:  return 8'h00;  // 0x8..0xB
      7'd10: return 8'h20;  7'd11: return 8'h00;
      7'd32: return 8'h78;  7'd33: return 8'h56;  // 0x200..0x203
      7'd34: return 8'h34;  7'd35: return 8'h12;
      7'd48: return 8'h11;  7'd49: return 8'h22;  // 0x300..0x303
      7'd50: return 8'hEE;  7'd51: return 8'h33;
      7'd127: return 8'hA5;                       // 0xFFFFFFFF
      7'd0:   return 8'h5A;                       // 0x00000000
      default: return 8'h00;
    endcase
  endfunction

  // RAM read data is valid one cycle after the address; reset reloads contents.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_byte(7'(i));
    end else if (bus.ram_wr_o === 1'b1) begin
      ram[ridx(bus.ram_addr_o)] <= bus.ram_dout_o;
    end
    bus.ram_din_i <= ram[ridx(bus.ram_addr_o)];
  end

  // Illegal length codes must never be presented by the requester.
  always @(posedge clk) begin
    if (bus.mem_req_i === 1'b1) begin
      assert (bus.mem_len_i == 3'd1 || bus.mem_len_i == 3'd2 || bus.mem_len_i == 3'd4)
      else $error("illegal mem_len_i %0d", bus.mem_len_i);
    end
  end

  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  done_t done_q[$];
  wr_t   wr_q[$];

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: compares every done pulse and RAM write against the queues.
  always @(negedge clk) begin
    done_t e;
    wr_t   w;
    if (bus.if_done_o === 1'b1 || bus.mem_done_o === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", {bus.if_done_o, bus.mem_done_o}, 2'b00);
      end else begin
        e = done_q.pop_front();
        check("done_kind", {bus.if_done_o, bus.mem_done_o}, e.is_if ? 2'b10 : 2'b01);
        check("done_cycle", cyc, e.cyc);
        if (e.chk_data)
          check("done_data", e.is_if ? bus.if_inst_o : bus.mem_rdata_o, e.data);
      end
    end
    if (bus.ram_wr_o === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {bus.ram_addr_o, bus.ram_dout_o}, 40'h0);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", bus.ram_addr_o, w.addr);
        check("wr_data", bus.ram_dout_o, w.data);
        check("wr_cycle", cyc, w.cyc);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push_done(input bit is_if, input bit chk, input logic [31:0] d, input int c);
    done_t e;
    e.is_if = is_if; e.chk_data = chk; e.data = d; e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    wr_q.push_back(w);
  endtask

  task automatic issue_if(input logic [31:0] a, input logic [31:0] exp_inst);
    bus.if_addr_i = a;
    bus.if_req_i  = 1'b1;
    push_done(1'b1, 1'b1, exp_inst, cyc + 6);
  endtask

  task automatic issue_mem(input bit we, input logic [2:0] len, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    int t;
    t = cyc;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = we;
    bus.mem_len_i   = len;
    bus.mem_addr_i  = a;
    bus.mem_wdata_i = wd;
    if (we) begin
      for (int k = 0; k < int'(len); k++) push_wr(a + 32'(k), wd[8*k +: 8], t + 1 + k);
      push_done(1'b0, 1'b0, 32'h0, t + int'(len) + 1);
    end else begin
      push_done(1'b0, 1'b1, exp_rd, t + int'(len) + 2);
    end
  endtask

  // Bounded wait for a done pulse; the request is dropped in the DONE cycle.
  task automatic wait_done(input bit is_if);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = is_if ? (bus.if_done_o === 1'b1) : (bus.mem_done_o === 1'b1);
    end
    check(is_if ? "if_done_wait" : "mem_done_wait", seen, 1'b1);
    if (is_if) bus.if_req_i = 1'b0;
    else       bus.mem_req_i = 1'b0;
  endtask

  function automatic logic [106:0] out_vec();
    return {bus.if_done_o, bus.mem_done_o, bus.if_inst_o, bus.mem_rdata_o,
            bus.ram_addr_o, bus.ram_wr_o, bus.ram_dout_o};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = 3'd4;
    bus.mem_addr_i = 32'h0; bus.mem_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 107'h0);
    align();
    rst = 1'b0;

    // IF fetch at 0x100, no RAM writes allowed.
    align();
    issue_if(32'h0000_0100, 32'h0010_0513);
    wait_done(1'b1);

    // Simultaneous requests: MEM first (t+6), then IF (granted t+7, done t+13).
    align();
    issue_mem(1'b0, 3'd4, 32'h0000_0200, 32'h0, 32'h1234_5678);
    bus.if_addr_i = 32'h0000_0008;
    bus.if_req_i  = 1'b1;
    push_done(1'b1, 1'b1, 32'h0020_0093, cyc + 13);
    fork
      wait_done(1'b0);
      wait_done(1'b1);
    join

    // Store two bytes at 0x300; 0x302 must keep its old value.
    align();
    issue_mem(1'b1, 3'd2, 32'h0000_0300, 32'hAABB_CCDD, 32'h0);
    wait_done(1'b0);
    check("ram_0x300", ram[ridx(32'h300)], 8'hDD);
    check("ram_0x301", ram[ridx(32'h301)], 8'hCC);
    check("ram_0x302", ram[ridx(32'h302)], 8'hEE);

    // Loads at the top of the address space, second one wraps to 0.
    align();
    issue_mem(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_00A5);
    wait_done(1'b0);
    align();
    issue_mem(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0, 32'h0000_5AA5);
    wait_done(1'b0);

    // Flush in the second IF_RD cycle, then a fresh fetch to 0x8.
    align();
    bus.if_addr_i = 32'h0000_0100;
    bus.if_req_i  = 1'b1;
    align();
    align();
    bus.flush_i  = 1'b1;
    bus.if_req_i = 1'b0;
    align();
    bus.flush_i = 1'b0;
    issue_if(32'h0000_0008, 32'h0020_0093);
    @(negedge clk);
    check("flush_inst_kept", bus.if_inst_o, 32'h0020_0093);
    wait_done(1'b1);

    // Reset in the middle of a 4-byte store: only two bytes go out.
    align();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 3'd4;
    bus.mem_addr_i = 32'h0000_0400; bus.mem_wdata_i = 32'h1122_3344;
    push_wr(32'h0000_0400, 8'h44, cyc + 1);
    push_wr(32'h0000_0401, 8'h33, cyc + 2);
    align();
    align();
    rst = 1'b1;
    bus.mem_req_i = 1'b0;
    align();
    rst = 1'b0;
    @(negedge clk);
    check("midwrite_reset_outputs", out_vec(), 107'h0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("done_queue_drained", done_q.size(), 0);
    check("write_queue_drained", wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
